regbus_xfer_ctrl: RTL
=====================

Name: regbus_xfer_ctrl

Overview:
Sequencer for the shared tristate data bus that links a bank of CS/WE/OE registers. It accepts one transfer request at a time: register-to-register move, load-immediate or register read-out. It then drives the per-register chip-select, write-enable and output-enable strobes in a fixed contention-free order. It sits between the CPU control unit and the register bank and is the only agent that drives register strobes.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), bus and immediate width
NUM_REGS, 4, number of registers on the bus
SEL_WIDTH, 2, register index width; must satisfy 2**SEL_WIDTH >= NUM_REGS

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_op  input  2  0=MOV, 1=LDI, 2=RD, 3=illegal
req_src  input  SEL_WIDTH  source register index (MOV, RD)
req_dst  input  SEL_WIDTH  destination register index (MOV, LDI)
req_imm  input  DATA_WIDTH  immediate value (LDI)
busy  output  1  transfer in progress (state != IDLE)
done  output  1  one-cycle completion pulse
err  output  1  valid only with done; 1 = request rejected
rd_data  output  DATA_WIDTH  value captured by the last RD
reg_cs  output  NUM_REGS  per-register chip select
reg_we  output  NUM_REGS  per-register write enable
reg_oe  output  NUM_REGS  per-register output enable
bus  inout  DATA_WIDTH  shared data bus; driven with the immediate only during LDI

Behaviour:
- All outputs are registered.
- Reset (asynchronous) forces state to IDLE, with reg_cs, reg_we and reg_oe all 0, bus at high-Z, done=0, err=0, rd_data=0 and req_ready=0.
- req_ready goes to 1 on the first clock edge after reset deasserts. req_ready equals 1 only in IDLE.
- A request is accepted on an edge where req_valid=1 and req_ready=1. op, src, dst and imm are latched internally at that edge, so the requester may change its inputs afterwards.
- States: IDLE, SETUP, WRITE, HOLD, DONE.
- The following requests are rejected (IDLE goes directly to DONE, no strobes asserted, err=1):
  - op=3;
  - src index >= NUM_REGS for MOV or RD;
  - dst index >= NUM_REGS for MOV or LDI.
- MOV with src==dst is a legal NOP: IDLE goes directly to DONE, no strobes asserted, err=0.
- SETUP (1 cycle): the source drives the bus.
  - MOV/RD: reg_cs[src]=1 and reg_oe[src]=1.
  - LDI: the controller drives req_imm onto the bus.
- WRITE (1 cycle): the source keeps driving.
  - MOV/LDI: reg_cs[dst]=1 and reg_we[dst]=1. The destination's dff captures the bus value on the edge that ends WRITE.
  - RD: no WE is asserted. rd_data is loaded from the bus on the edge that ends WRITE.
- HOLD (1 cycle): all WE are 0 and the source still drives the bus. This closes the destination latch while the bus is stable.
- DONE (1 cycle): all strobes are 0, the bus is high-Z, done=1 and err is valid. The next state is IDLE.
- Accepted legal transfers: accept edge, then SETUP, WRITE, HOLD, DONE, then IDLE. Latency is 4 cycles to done; throughput is one transfer per 5 cycles.
- Rejected transfers and NOPs: done is asserted 1 cycle after acceptance.
- Invariants that must hold in every cycle:
  - at most one bit of reg_oe is set;
  - at most one bit of reg_we is set;
  - controller bus drive and any reg_oe bit are never both active;
  - reg_we[i] implies reg_cs[i];
  - reg_oe[i] implies reg_cs[i];
  - reg_we never rises in the same cycle that the source starts driving (SETUP always precedes WRITE).
- Requests presented while busy are not accepted and are held off by req_ready=0; they are neither queued nor dropped.
- rd_data holds its value until the next successful RD. MOV and LDI do not alter it.
- Reset in mid-transfer asynchronously clears all strobes and releases the bus. The destination register contents are then undefined only if reset lands in WRITE; done is not generated for the aborted transfer.

Test Plan:
- Reset then LDI dst=2, imm=8'hA5: req_ready=1 one edge after reset release; reg_we[2] high exactly in cycle 2 after accept; done at cycle 4 with err=0; a following RD src=2 returns rd_data=8'hA5.
- LDI r0=8'h3C, then MOV src=0 dst=3, then RD src=3: rd_data=8'h3C. Per-cycle checks during MOV: reg_oe=4'b0001 in SETUP/WRITE/HOLD, reg_we=4'b1000 only in WRITE, bus never driven by the controller.
- Back-to-back requests with req_valid held high: second accept occurs exactly 5 cycles after the first; req_ready=0 throughout busy; the second request's inputs are changed while busy and the values present at its accept edge are used.
- op=3, and MOV src=0 dst=0: done asserted 1 cycle after accept with err=1 and err=0 respectively; no strobe bit set at any time; register contents unchanged.
- Reset asserted during HOLD of a MOV: all strobes 0 and bus at high-Z immediately (asynchronous); no done pulse; after release, req_ready=1 and a new LDI completes normally.
- Contention monitor over 200 random legal/illegal requests: the one-hot-or-zero rules for reg_oe and reg_we, and exclusive bus drive, hold every cycle; every RD matches the scoreboard value.

Source files
------------

// File: rtl/regbus_xfer_ctrl.sv
// regbus_xfer_ctrl: sequences one register-bus transfer at a time (MOV, LDI, RD).
// It drives the per-register CS/WE/OE strobes in a fixed order, so that there is
// never more than one driver on the shared bus and a write never opens while the
// source is still starting to drive. Every output comes straight from a flop.
module regbus_xfer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4,
    parameter int SEL_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [SEL_WIDTH-1:0]  req_src,
    input  logic [SEL_WIDTH-1:0]  req_dst,
    input  logic [DATA_WIDTH-1:0] req_imm,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [NUM_REGS-1:0]   reg_cs,
    output logic [NUM_REGS-1:0]   reg_we,
    output logic [NUM_REGS-1:0]   reg_oe,
    inout  wire  [DATA_WIDTH-1:0] bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] OP_MOV = 2'd0;
    localparam logic [1:0] OP_LDI = 2'd1;
    localparam logic [1:0] OP_RD  = 2'd2;

    // True when a register index names no register on the bus.
    function automatic logic idx_bad(input logic [SEL_WIDTH-1:0] idx);
        return (32'(idx) >= 32'(NUM_REGS));
    endfunction

    // Single-bit strobe mask for a register index. Out-of-range indices give no bit.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(idx) == 32'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    state_e                  state_q, state_d;
    logic [1:0]              op_q;
    logic [SEL_WIDTH-1:0]    src_q, dst_q;
    logic [DATA_WIDTH-1:0]   imm_q;
    logic                    rej_q;
    logic                    drv_q, drv_d;
    logic                    ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [NUM_REGS-1:0]     cs_q, cs_d, we_q, we_d, oe_q, oe_d;
    logic [DATA_WIDTH-1:0]   rd_q;

    logic                    accept_s, req_bad_s, nop_s, rej_s;
    logic [1:0]              op_s;
    logic [SEL_WIDTH-1:0]    src_s, dst_s;

    // Classify the incoming request: rejected, MOV-to-self NOP, or a real transfer.
    always_comb begin
        accept_s = req_valid & ready_q;
        case (req_op)
            OP_MOV:  req_bad_s = idx_bad(req_src) | idx_bad(req_dst);
            OP_LDI:  req_bad_s = idx_bad(req_dst);
            OP_RD:   req_bad_s = idx_bad(req_src);
            default: req_bad_s = 1'b1;
        endcase
        nop_s = (req_op == OP_MOV) && (req_src == req_dst);
        if (accept_s) begin
            op_s  = req_op;
            src_s = req_src;
            dst_s = req_dst;
            rej_s = req_bad_s;
        end else begin
            op_s  = op_q;
            src_s = src_q;
            dst_s = dst_q;
            rej_s = rej_q;
        end
    end

    // Next state and next values of the registered outputs (decoded from the next state).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_bad_s || nop_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_HOLD;
            ST_HOLD:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        cs_d  = '0;
        we_d  = '0;
        oe_d  = '0;
        drv_d = 1'b0;
        case (state_d)
            ST_SETUP, ST_WRITE, ST_HOLD: begin
                // The source drives the bus from SETUP through HOLD.
                if (op_s == OP_LDI) begin
                    drv_d = 1'b1;
                end else begin
                    cs_d = onehot(src_s);
                    oe_d = onehot(src_s);
                end
                // Only WRITE opens the destination. RD has no destination.
                if ((state_d == ST_WRITE) && (op_s != OP_RD)) begin
                    cs_d = cs_d | onehot(dst_s);
                    we_d = onehot(dst_s);
                end else begin
                    we_d = '0;
                end
            end
            default: begin
                cs_d  = '0;
                we_d  = '0;
                oe_d  = '0;
                drv_d = 1'b0;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        err_d   = (state_d == ST_DONE) & rej_s;
    end

    // State, output flops, latched request fields and the RD capture register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 2'd0;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            rej_q   <= 1'b0;
            drv_q   <= 1'b0;
            cs_q    <= '0;
            we_q    <= '0;
            oe_q    <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            drv_q   <= drv_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept_s) begin
                op_q  <= req_op;
                src_q <= req_src;
                dst_q <= req_dst;
                imm_q <= req_imm;
                rej_q <= req_bad_s;
            end
            // Capture on the edge that ends WRITE, while the source is still driving.
            if ((state_q == ST_WRITE) && (op_q == OP_RD)) begin
                rd_q <= bus;
            end
        end
    end

    assign bus       = drv_q ? imm_q : {DATA_WIDTH{1'bz}};
    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_data   = rd_q;
    assign reg_cs    = cs_q;
    assign reg_we    = we_q;
    assign reg_oe    = oe_q;

endmodule
